// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store unit: op and state encodings,
// default memory depth, and request classification helpers.
package mem_access_unit_pkg;

  localparam int MEM_WORDS_DEFAULT = 1024;

  typedef enum logic [2:0] {
    OP_LW  = 3'b000,
    OP_LH  = 3'b001,
    OP_LHU = 3'b010,
    OP_LB  = 3'b011,
    OP_LBU = 3'b100,
    OP_SW  = 3'b101,
    OP_SH  = 3'b110,
    OP_SB  = 3'b111
  } mem_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_RDWAIT = 3'd2,
    ST_WR     = 3'd3,
    ST_RESP   = 3'd4
  } mau_state_e;

  function automatic logic is_load(mem_op_e op);
    return (op != OP_SW) && (op != OP_SH) && (op != OP_SB);
  endfunction

  // Natural alignment: words on 4-byte, halfwords on 2-byte boundaries.
  function automatic logic misaligned(mem_op_e op, logic [1:0] lo);
    case (op)
      OP_LW, OP_SW:         return lo != 2'b00;
      OP_LH, OP_LHU, OP_SH: return lo[0];
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Combinational lane handling: load extraction with sign/zero extension,
// and merge of store data into a word read back from memory.
module mem_access_unit_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  byte_sel,
  input  logic [31:0] mem_word,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic [3:0]  lane_sel;
  logic [31:0] lane_src;

  always_comb begin
    byte_val  = mem_word[{byte_sel, 3'b000} +: 8];
    half_val  = byte_sel[1] ? mem_word[31:16] : mem_word[15:0];
    load_data = 32'h0;
    case (op)
      OP_LW:   load_data = mem_word;
      OP_LH:   load_data = {{16{half_val[15]}}, half_val};
      OP_LHU:  load_data = {16'h0, half_val};
      OP_LB:   load_data = {{24{byte_val[7]}}, byte_val};
      OP_LBU:  load_data = {24'h0, byte_val};
      default: load_data = 32'h0;
    endcase
  end

  // Each lane either takes its slice of the store data or keeps the memory byte.
  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    assign lane_sel[gi] = (op == OP_SW)
                        || ((op == OP_SH) && (byte_sel[1] == LANE[1]))
                        || ((op == OP_SB) && (byte_sel == LANE));
    assign lane_src[8*gi +: 8] = (op == OP_SB) ? store_data[7:0]
                               : (op == OP_SH) ? store_data[8*(gi%2) +: 8]
                               : store_data[8*gi +: 8];
    assign merged_word[8*gi +: 8] = lane_sel[gi] ? lane_src[8*gi +: 8]
                                                 : mem_word[8*gi +: 8];
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between the datapath and a word-wide data memory:
// one request at a time, sub-word stores done as read-modify-write.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic [2:0]  reqOp,
  input  logic [31:0] reqAddr,
  input  logic [31:0] reqWData,
  output logic        respValid,
  output logic [31:0] respData,
  output logic        respErr,
  output logic [31:0] memAddress,
  output logic [31:0] memWriteData,
  output logic        memWrite,
  output logic        memRead,
  input  logic [31:0] memReadData
);

  localparam logic [31:0] MEM_WORDS_LIMIT = 32'(MEM_WORDS);

  mau_state_e  state_reg;
  mem_op_e     op_reg;
  logic [1:0]  addr_lo_reg;
  logic [31:0] wdata_reg;

  logic        req_ready_reg;
  logic        resp_valid_reg;
  logic [31:0] resp_data_reg;
  logic        resp_err_reg;
  logic [31:0] mem_address_reg;
  logic [31:0] mem_write_data_reg;
  logic        mem_write_reg;
  logic        mem_read_reg;

  mem_op_e     req_op;
  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] merged_word;

  assign req_op  = mem_op_e'(reqOp);
  assign req_err = misaligned(req_op, reqAddr[1:0])
                 || ({2'b00, reqAddr[31:2]} >= MEM_WORDS_LIMIT);

  mem_access_unit_lane_align lane_align (
    .op          (op_reg),
    .byte_sel    (addr_lo_reg),
    .mem_word    (memReadData),
    .store_data  (wdata_reg),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg          <= ST_IDLE;
      op_reg             <= OP_LW;
      addr_lo_reg        <= 2'b00;
      wdata_reg          <= 32'h0;
      req_ready_reg      <= 1'b1;
      resp_valid_reg     <= 1'b0;
      resp_data_reg      <= 32'h0;
      resp_err_reg       <= 1'b0;
      mem_address_reg    <= 32'h0;
      mem_write_data_reg <= 32'h0;
      mem_write_reg      <= 1'b0;
      mem_read_reg       <= 1'b0;
    end else begin
      // Pulse-type outputs default low; each state raises only its own.
      resp_valid_reg <= 1'b0;
      resp_data_reg  <= 32'h0;
      resp_err_reg   <= 1'b0;
      mem_write_reg  <= 1'b0;
      mem_read_reg   <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (reqValid) begin
            op_reg        <= req_op;
            addr_lo_reg   <= reqAddr[1:0];
            wdata_reg     <= reqWData;
            req_ready_reg <= 1'b0;
            if (req_err) begin
              state_reg      <= ST_RESP;
              resp_valid_reg <= 1'b1;
              resp_err_reg   <= 1'b1;
            end else begin
              mem_address_reg <= {2'b00, reqAddr[31:2]};
              if (req_op == OP_SW) begin
                state_reg          <= ST_WR;
                mem_write_reg      <= 1'b1;
                mem_write_data_reg <= reqWData;
              end else begin
                state_reg    <= ST_RD;
                mem_read_reg <= 1'b1;
              end
            end
          end
        end
        ST_RD: state_reg <= ST_RDWAIT;
        ST_RDWAIT: begin
          // Read word is on memReadData now: finish the load or the RMW merge.
          if (is_load(op_reg)) begin
            state_reg      <= ST_RESP;
            resp_valid_reg <= 1'b1;
            resp_data_reg  <= load_data;
          end else begin
            state_reg          <= ST_WR;
            mem_write_reg      <= 1'b1;
            mem_write_data_reg <= merged_word;
          end
        end
        ST_WR: begin
          state_reg      <= ST_RESP;
          resp_valid_reg <= 1'b1;
        end
        ST_RESP: begin
          state_reg     <= ST_IDLE;
          req_ready_reg <= 1'b1;
        end
        default: begin
          state_reg     <= ST_IDLE;
          req_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign reqReady     = req_ready_reg;
  assign respValid    = resp_valid_reg;
  assign respData     = resp_data_reg;
  assign respErr      = resp_err_reg;
  assign memAddress   = mem_address_reg;
  assign memWriteData = mem_write_data_reg;
  assign memWrite     = mem_write_reg;
  assign memRead      = mem_read_reg;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter MEM_WORDS, default 1024: number of 32-bit words in the attached data memory.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 reqValid  input  1  datapath presents a memory operation.
REQ-005 reqReady  output  1  unit can accept a request this cycle.
REQ-006 reqOp  input  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB.
REQ-007 reqAddr  input  32  byte address.
REQ-008 reqWData  input  32  store data; SH uses [15:0], SB uses [7:0].
REQ-009 respValid  output  1  one-cycle pulse: operation complete.
REQ-010 respData  output  32  load result, extended per reqOp; 0 for stores and errors.
REQ-011 respErr  output  1  valid with respValid: misaligned or out-of-range access.
REQ-012 memAddress  output  32  word index to data memory (reqAddr[31:2]).
REQ-013 memWriteData  output  32  full word to data memory.
REQ-014 memWrite  output  1  data memory write strobe.
REQ-015 memRead  output  1  data memory read strobe.
REQ-016 memReadData  input  32  data memory read word; valid the cycle after memRead.

Function
REQ-017 Accept: reqValid && reqReady at a rising edge; reqOp/reqAddr/reqWData captured; reqReady=1 only in IDLE.
REQ-018 States: IDLE, RD, RDWAIT, WR, RESP.
REQ-019 Transitions: IDLE->RESP on error; IDLE->RD on loads, SH, SB; IDLE->WR on SW; RD->RDWAIT; RDWAIT->RESP for loads, ->WR for SH/SB; WR->RESP; RESP->IDLE.
REQ-020 RD: memRead=1, memAddress=word index; RDWAIT: memRead=0, memReadData registered at end of cycle.
REQ-021 WR: memWrite=1 for exactly one cycle with memAddress and memWriteData stable the whole cycle.
REQ-022 memRead and memWrite never both 1; both 0 outside RD/WR; memAddress/memWriteData hold last value when idle.
REQ-023 Little-endian lanes: byte k = word[8k+7:8k]; halfword at addr[1]=h = word[16h+15:16h].
REQ-024 LB/LH sign-extend, LBU/LHU zero-extend, LW passes word unchanged.
REQ-025 SH/SB read-modify-write: only the addressed lane(s) replaced from reqWData; other lanes keep memory value.
REQ-026 Error when LW/SW addr[1:0]!=0, LH/LHU/SH addr[0]!=0, or addr[31:2] >= MEM_WORDS; no memory strobe issued.
REQ-027 Latency from accept edge to respValid cycle: LW 3, LB/LBU/LH/LHU 3, SW 2, SH/SB 4, error 1 cycle.
REQ-028 respValid lasts exactly one cycle (RESP); respData/respErr valid only then, 0 otherwise.
REQ-029 No back-to-back accept: next request accepted no earlier than cycle after RESP.
REQ-030 reqValid while busy is ignored and does not alter captured request.

Reset
REQ-031 rst_n low: state=IDLE, reqReady=1, respValid=0, respErr=0, respData=0, memRead=0, memWrite=0, memAddress=0, memWriteData=0, immediately (asynchronous).
REQ-032 Reset mid-operation aborts it: no response, partially built RMW word discarded, no memWrite issued after reset release until a new store is accepted.

Structure
REQ-033 Shared package holds op encodings, state encoding, and MEM_WORDS default.
REQ-034 One sub-module, lane_align: combinational load extract/extend and store lane-merge.

Verification
REQ-035 SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> memWrite once at word 4; LW respData=0xDEADBEEF, 3 cycles.
REQ-036 Word 4=0x11223344; SB addr 0x12 data 0xAA -> memory 0x11AA3344, respValid 4 cycles after accept.
REQ-037 Word 4=0x80FF7F01; LB 0x13->0xFFFFFF80, LBU 0x13->0x00000080, LH 0x12->0xFFFF80FF, LHU 0x10->0x00007F01.
REQ-038 LW 0x11, SH 0x13, LW 0x1000 (MEM_WORDS=1024) -> respErr=1, respData=0, no memRead/memWrite, 1-cycle latency.
REQ-039 SH accepted, rst_n pulsed low during RDWAIT -> all outputs at reset values immediately, memory word unchanged, no respValid.
REQ-040 reqValid held high continuously with mixed ops -> reqReady low while busy, each op accepted once, responses in order.
